// File: rtl/smps_pkg.sv
// Shared definitions for the SMPS duty path.
// Used by the soft-start stage and the PWM generator.
package smps_pkg;

    localparam int PWM_DUTY_W   = 8;
    localparam int PWM_MAX_DUTY = 230;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RUN,
        RAMP_DOWN
    } state_t;

endpackage

// File: rtl/step_timer.sv
// Step-interval prescaler for the soft-start ramp.
// Raises a sticky step request every STEP_DIV clocks while running.
module step_timer #(
    parameter int STEP_DIV = 2000,
    parameter int DIV_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic consume,
    output logic step_pending
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] cnt;
    logic             term;

    assign term = (cnt == LAST);

    // A fresh interval wins over a same-cycle consume
    always_ff @(posedge clk) begin
        if (!rst || !run) begin
            cnt          <= '0;
            step_pending <= 1'b0;
        end else begin
            cnt          <= term ? '0 : cnt + 1'b1;
            step_pending <= term | (step_pending & ~consume);
        end
    end

endmodule

// File: rtl/soft_start_ramp.sv
// Slew-limited duty command with soft start/stop for the PWM stage.
// Steps are applied only on PWM period ticks.
module soft_start_ramp
    import smps_pkg::*;
#(
    parameter int DUTY_W   = PWM_DUTY_W,
    parameter int STEP     = 1,
    parameter int STEP_DIV = 2000,
    parameter int DIV_W    = 16,
    parameter int MAX_DUTY = PWM_MAX_DUTY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] i_target_duty,
    input  logic              i_period_tick,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_pwm_en,
    output logic              o_ramping,
    output logic              o_done
);

    localparam int              AW     = DUTY_W + 1;
    localparam logic [AW-1:0]   STEP_A = AW'(STEP);
    localparam logic [AW-1:0]   MAX_A  = AW'(MAX_DUTY);

    state_t        state;
    state_t        state_n;
    logic          step_pending;
    logic          running;
    logic          apply;
    logic [AW-1:0] tgt;
    logic [AW-1:0] aim;
    logic [AW-1:0] cur;
    logic [AW-1:0] nd;

    assign running = (state != IDLE);
    assign apply   = step_pending & i_period_tick & running;

    step_timer #(
        .STEP_DIV (STEP_DIV),
        .DIV_W    (DIV_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .run          (running),
        .consume      (apply),
        .step_pending (step_pending)
    );

    // Stopping aims at zero; running aims at the clamped setpoint
    always_comb begin
        cur = {1'b0, o_duty};
        tgt = ({1'b0, i_target_duty} > MAX_A) ? MAX_A : {1'b0, i_target_duty};
        aim = enable ? tgt : '0;
        nd  = cur;
        if (apply) begin
            if (cur < aim)
                nd = (cur + STEP_A > aim) ? aim : cur + STEP_A;
            else if (cur > aim)
                nd = (cur < aim + STEP_A) ? aim : cur - STEP_A;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (enable)
                    state_n = RAMP_UP;
            end
            default: begin
                if (!enable)
                    state_n = (nd == '0) ? IDLE : RAMP_DOWN;
                else if (apply && state != RUN)
                    state_n = (nd == tgt) ? RUN : RAMP_UP;
                else if (state == RAMP_DOWN)
                    state_n = RAMP_UP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            o_duty    <= '0;
            o_pwm_en  <= 1'b0;
            o_ramping <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_n;
            o_duty    <= nd[DUTY_W-1:0];
            o_pwm_en  <= (state_n != IDLE);
            o_done    <= (state_n == RUN) && (nd == tgt);
            o_ramping <= (state_n == RAMP_DOWN) ||
                         ((state_n != IDLE) && (nd != tgt));
        end
    end

endmodule

// File: tb/tb_soft_start_ramp.sv
// Scoreboard bench for soft_start_ramp.
// Two instances: STEP=1 and STEP=4, sharing stimulus.
module tb_soft_start_ramp;

    localparam logic [2:0] OFF  = 3'b000;
    localparam logic [2:0] RAMP = 3'b101;
    localparam logic [2:0] DONE = 3'b110;
    localparam logic [2:0] ALL  = 3'b111;

    typedef struct {
        logic [7:0] duty;
        logic [2:0] flg;
        logic [2:0] msk;
        bit         which;
        string      name;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       enable   = 1'b0;
    logic       tick     = 1'b0;
    logic       probe    = 1'b0;
    logic       strobe_d = 1'b0;
    logic [7:0] target   = 8'd0;

    logic [7:0] duty1;
    logic [7:0] duty4;
    logic       pwm1, ramp1, done1;
    logic       pwm4, ramp4, done4;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    soft_start_ramp #(
        .DUTY_W(8), .STEP(1), .STEP_DIV(4), .DIV_W(16), .MAX_DUTY(230)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .i_target_duty(target), .i_period_tick(tick),
        .o_duty(duty1), .o_pwm_en(pwm1),
        .o_ramping(ramp1), .o_done(done1)
    );

    soft_start_ramp #(
        .DUTY_W(8), .STEP(4), .STEP_DIV(4), .DIV_W(16), .MAX_DUTY(230)
    ) dut4 (
        .clk(clk), .rst(rst), .enable(enable),
        .i_target_duty(target), .i_period_tick(tick),
        .o_duty(duty4), .o_pwm_en(pwm4),
        .o_ramping(ramp4), .o_done(done4)
    );

    always @(posedge clk) strobe_d <= tick | probe;

    // Monitor: one expected entry per tick/probe strobe
    initial begin
        exp_t       e;
        logic [7:0] ad;
        logic [2:0] af;
        forever begin
            @(negedge clk);
            if (strobe_d) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL underflow: output strobe with no expected entry");
                end else begin
                    e  = q.pop_front();
                    ad = e.which ? duty4 : duty1;
                    af = e.which ? {pwm4, done4, ramp4} : {pwm1, done1, ramp1};
                    if (ad !== e.duty || ((af ^ e.flg) & e.msk) !== 3'b000) begin
                        n_fail++;
                        $display("FAIL %s: duty=%0d flags(pwm,done,ramp)=%b, expected duty=%0d flags=%b mask=%b",
                                 e.name, ad, af, e.duty, e.flg, e.msk);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic pulse(input bit is_tick, input logic [7:0] d,
                         input logic [2:0] f, input logic [2:0] m,
                         input bit w, input string nm);
        exp_t e;
        e.duty  = d;
        e.flg   = f;
        e.msk   = m;
        e.which = w;
        e.name  = nm;
        q.push_back(e);
        if (is_tick) tick = 1'b1;
        else         probe = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        probe = 1'b0;
    endtask

    task automatic step(input logic [7:0] d, input logic [2:0] f,
                        input logic [2:0] m, input bit w, input string nm);
        repeat (7) @(negedge clk);
        pulse(1'b1, d, f, m, w, nm);
    endtask

    initial begin
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
        target = 8'd5;
        repeat (2) @(negedge clk);
        pulse(1'b0, 8'd0, OFF, ALL, 1'b0, "reset");
        rst = 1'b1;
        pulse(1'b0, 8'd0, RAMP, ALL, 1'b0, "release");
        for (int v = 1; v <= 5; v++)
            step(8'(v), (v == 5) ? DONE : RAMP, ALL, 1'b0, "ramp_up");

        enable = 1'b0;
        pulse(1'b0, 8'd5, RAMP, ALL, 1'b0, "stop_hold");
        for (int v = 4; v >= 1; v--)
            step(8'(v), RAMP, ALL, 1'b0, "ramp_down");
        step(8'd0, OFF, 3'b010, 1'b0, "ramp_zero");
        repeat (2) @(negedge clk);
        pulse(1'b0, 8'd0, OFF, ALL, 1'b0, "idle");

        enable = 1'b1;
        for (int v = 1; v <= 5; v++)
            step(8'(v), (v == 5) ? DONE : RAMP, ALL, 1'b0, "restart");
        enable = 1'b0;
        for (int v = 4; v >= 2; v--)
            step(8'(v), RAMP, ALL, 1'b0, "stop2");
        enable = 1'b1;
        pulse(1'b0, 8'd2, RAMP, ALL, 1'b0, "reenable");
        for (int v = 3; v <= 5; v++)
            step(8'(v), (v == 5) ? DONE : RAMP, ALL, 1'b0, "resume");

        target = 8'd2;
        pulse(1'b0, 8'd5, RAMP, ALL, 1'b0, "retarget");
        step(8'd4, RAMP, ALL, 1'b0, "retarget_dn");
        step(8'd3, RAMP, ALL, 1'b0, "retarget_dn");
        step(8'd2, DONE, ALL, 1'b0, "retarget_dn");

        target = 8'd250;
        for (int v = 3; v <= 230; v++)
            step(8'(v), (v == 230) ? DONE : RAMP, ALL, 1'b0, "saturate");
        step(8'd230, DONE, ALL, 1'b0, "sat_hold");

        rst = 1'b0;
        repeat (2) @(negedge clk);
        target = 8'd5;
        rst    = 1'b1;
        for (int v = 1; v <= 3; v++)
            step(8'(v), RAMP, ALL, 1'b0, "mid");
        repeat (40) @(negedge clk);
        pulse(1'b0, 8'd3, RAMP, ALL, 1'b0, "no_tick");
        rst = 1'b0;
        pulse(1'b0, 8'd0, OFF, ALL, 1'b0, "mid_reset");

        target = 8'd6;
        rst    = 1'b1;
        pulse(1'b0, 8'd0, RAMP, ALL, 1'b1, "s4_release");
        step(8'd4, RAMP, ALL, 1'b1, "s4_up");
        step(8'd6, DONE, ALL, 1'b1, "s4_clamp");
        step(8'd6, DONE, ALL, 1'b1, "s4_hold");

        rst = 1'b0;
        @(negedge clk);
        target = 8'd0;
        rst    = 1'b1;
        pulse(1'b0, 8'd0, 3'b100, ALL, 1'b0, "zero_release");
        step(8'd0, DONE, ALL, 1'b0, "zero_run");

        repeat (5) @(negedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
